alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Shares one combinational ALU between two requesters, the execute path (port 0) and the branch-compare path (port 1), using valid/ready handshakes. A round-robin arbiter grants at most one request per cycle. The ALU result is captured in a one-entry output register and returned only to the requester that was granted. The block sits between the decode/issue logic and the ALU datapath, so both clients can use a single ALU instance.

## Interface
Parameters:
- `W`, default 32: operand and result width.
- `OPW`, default 5: ALU opcode width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0_valid` in 1: port 0 request present.
- `req0_ready` out 1: port 0 request accepted this cycle.
- `req0_op` in OPW: port 0 ALU opcode.
- `req0_a` in W: port 0 operand A.
- `req0_b` in W: port 0 operand B.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same meanings for port 1.
- `rsp0_valid` out 1: result for port 0 held.
- `rsp0_ready` in 1: port 0 consumes the result.
- `rsp1_valid` out 1: result for port 1 held.
- `rsp1_ready` in 1: port 1 consumes the result.
- `rsp_y` out W: registered ALU result, shared by both response channels.
- `rsp_zero` out 1: registered zero flag, set when `rsp_y` is 0.
- `rsp_err` out 1: registered flag; the opcode was outside 0..15.

## Operation
- State machine:
  - EMPTY: no result held.
  - FULL: result held, with an owner bit `own`.
- Accept condition:
  - `can_acc` = EMPTY, or FULL and the owner's `rsp_ready` = 1.
  - `reqN_ready` = `can_acc` && `grant == N`.
- Arbitration, evaluated combinationally each cycle:
  - Only one port valid: that port wins.
  - Both ports valid: the port not equal to `last` wins.
  - `last` updates to the winner only when a request is accepted.
  - `last` resets to 1, so port 0 has first priority.
- On accept:
  - The winner's op/a/b drive the ALU.
  - `rsp_y` ← ALU Y; `rsp_zero` ← (Y == 0); `rsp_err` ← (op > 15).
  - `own` ← winner; state → FULL.
- Invalid opcode: Y = 0, so `rsp_zero` = 1 and `rsp_err` = 1. The request is still accepted and responded to.
- FULL, owner `rsp_ready` = 1, no accept: state → EMPTY.
- FULL, owner `rsp_ready` = 1, simultaneous accept: state stays FULL and the new result/owner load. This gives back-to-back throughput of 1 per cycle.
- `rsp_ready` from the non-owner port is ignored.
- `rspN_valid` = FULL && `own == N`.

## Timing
- Latency: the result appears the cycle after the accept edge.
- Sustained throughput: one operation per cycle when the owner holds `rsp_ready` high.
- Response outputs stay stable while `rspN_valid` = 1 and `rspN_ready` = 0.
- Request inputs only need to be valid in the cycle where `valid` && `ready`.
- Requesters must hold `valid` and payload until `ready` (standard valid/ready).
- Reset values (asynchronous assertion, synchronous-edge release):
  - State EMPTY, `own` = 0, `last` = 1.
  - `rsp_y` = 0, `rsp_zero` = 0, `rsp_err` = 0.
  - `rsp0_valid` = `rsp1_valid` = 0.
  - `req0_ready` = `req1_ready` = 0 while `rst_n` = 0.
- Reset mid-operation: a held result is discarded and no response is produced.
- No combinational path from `reqN_valid` to `rspN_valid`.
- Combinational paths that do exist:
  - `reqN_valid` → `reqM_ready` (arbitration).
  - `rspN_ready` → `reqM_ready` (same-cycle reuse).

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum covering 0..15: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - `ALU_OP_MAX` = 15.
  - `OPW` and `W` defaults.
- The existing `ALU` module is instantiated once as the single sub-module.
- Arbiter, state register and output register live in this block's top level.
- Expected size: about 150–220 lines of RTL.

## Test plan
- Reset, then port 0 requests ADD, a = 5, b = 7, with `rsp0_ready` = 1.
  - Next cycle: `rsp0_valid` = 1, `rsp_y` = 12, `rsp_zero` = 0.
  - `rsp1_valid` stays 0.
- Both ports valid every cycle, both `rsp_ready` = 1.
  - Grants alternate 0, 1, 0, 1, … starting with port 0.
  - One response per cycle, each on the correct port.
- Port 1 requests BEQ, a = b = 0x1234, with `rsp1_ready` = 0 for 3 cycles.
  - `rsp_y` = 1 is held stable throughout.
  - `req0_ready` and `req1_ready` stay 0 while blocked.
  - The new request is accepted in the same cycle `rsp1_ready` rises.
- Port 0 sends op = 5'd20, a = 3, b = 4.
  - Response: `rsp_y` = 0, `rsp_zero` = 1, `rsp_err` = 1.
- SRA, a = 0x8000_0000, b = 4, then SLTU, a = 1, b = 0xFFFF_FFFF.
  - Responses: `rsp_y` = 0xF800_0000, then 1.
- FULL with port 1 owning, `rst_n` pulsed low mid-cycle.
  - All outputs go to reset values immediately.
  - No stale response appears after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and the ALU sharing controller.
//   alu_op_e    - 4-bit opcode encoding for the sixteen defined operations
//   ALU_OP_MAX  - highest defined opcode; anything above is an error
//   ALU_W       - default operand/result width
//   ALU_OPW     - default opcode width
//   share_st_e  - state of the one-entry result register
package alu_pkg;

   localparam int ALU_W      = 32;
   localparam int ALU_OPW    = 5;
   localparam int ALU_OP_MAX = 15;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_BEQ  = 4'd10,
      ALU_BNE  = 4'd11,
      ALU_BLT  = 4'd12,
      ALU_BGE  = 4'd13,
      ALU_BLTU = 4'd14,
      ALU_BGEU = 4'd15
   } alu_op_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } share_st_e;

endpackage

// File: rtl/alu.sv
// alu: purely combinational ALU.
//   op  in  OPW : opcode (alu_op_e in the low 4 bits; values above 15 are invalid)
//   a   in  W   : operand A
//   b   in  W   : operand B
//   y   out W   : result; 0 for invalid opcodes. Branch compares return 0/1.
module alu
   import alu_pkg::*;
#(
   parameter int W   = ALU_W,
   parameter int OPW = ALU_OPW
) (
   input  logic [OPW-1:0] op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [W-1:0]   y
);

   localparam int SHW = $clog2(W);

   logic [SHW-1:0] shamt;
   alu_op_e        opc;
   logic           op_ok;

   assign shamt = b[SHW-1:0];
   assign opc   = alu_op_e'(op[3:0]);
   assign op_ok = (op <= OPW'(ALU_OP_MAX));

   always_comb begin
      y = '0;
      if (op_ok) begin
         case (opc)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = W'($signed(a) < $signed(b));
            ALU_SLTU: y = W'(a < b);
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_BEQ:  y = W'(a == b);
            ALU_BNE:  y = W'(a != b);
            ALU_BLT:  y = W'($signed(a) < $signed(b));
            ALU_BGE:  y = W'($signed(a) >= $signed(b));
            ALU_BLTU: y = W'(a < b);
            ALU_BGEU: y = W'(a >= b);
            default:  y = '0;
         endcase
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between the execute path (port 0) and the
// branch-compare path (port 1). A round-robin arbiter picks at most one
// request per cycle; the result is held in a one-entry register and returned
// only on the response channel of the port that was granted.
//   clk, rst_n                         : clock, async active-low reset
//   req{0,1}_valid/ready/op/a/b        : request channels
//   rsp{0,1}_valid/ready               : response handshakes
//   rsp_y, rsp_zero, rsp_err           : registered result shared by both
//                                        response channels
//
// Handshakes: a transfer happens on a rising edge where valid && ready. The
// sender holds valid and payload stable until that edge. req*_ready depends
// combinationally on the other port's valid and on the owner's rsp*_ready;
// rsp*_valid is purely registered, so no request input reaches it directly.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int W   = ALU_W,
   parameter int OPW = ALU_OPW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [W-1:0]   rsp_y,
   output logic           rsp_zero,
   output logic           rsp_err
);

   share_st_e      state_q, state_d;
   logic           own_q;
   logic           last_q;

   logic           grant;
   logic           win_valid;
   logic           owner_ready;
   logic           can_acc;
   logic           accept;
   logic [OPW-1:0] sel_op;
   logic [W-1:0]   sel_a, sel_b;
   logic [W-1:0]   alu_y;

   // Arbitration: a lone requester wins; on contention the port that did not
   // win last time wins. With nothing valid grant rests on port 0.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = ~last_q;
      else if (req1_valid)          grant = 1'b1;
   end

   assign win_valid   = grant ? req1_valid : req0_valid;
   assign owner_ready = own_q ? rsp1_ready : rsp0_ready;
   // The slot can take a new result when empty, or when the current owner is
   // draining it this same cycle. rst_n gating keeps readies low in reset.
   assign can_acc     = rst_n && ((state_q == ST_EMPTY) || owner_ready);
   assign req0_ready  = can_acc && !grant;
   assign req1_ready  = can_acc && grant;
   assign accept      = can_acc && win_valid;

   assign sel_op = grant ? req1_op : req0_op;
   assign sel_a  = grant ? req1_a  : req0_a;
   assign sel_b  = grant ? req1_b  : req0_b;

   alu #(.W(W), .OPW(OPW)) u_alu (
      .op (sel_op),
      .a  (sel_a),
      .b  (sel_b),
      .y  (alu_y)
   );

   always_comb begin
      state_d = state_q;
      if (accept)                               state_d = ST_FULL;
      else if (state_q == ST_FULL && owner_ready) state_d = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         own_q    <= 1'b0;
         last_q   <= 1'b1;
         rsp_y    <= '0;
         rsp_zero <= 1'b0;
         rsp_err  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            own_q    <= grant;
            last_q   <= grant;
            rsp_y    <= alu_y;
            rsp_zero <= (alu_y == '0);
            rsp_err  <= (sel_op > OPW'(ALU_OP_MAX));
         end
      end
   end

   assign rsp0_valid = (state_q == ST_FULL) && !own_q;
   assign rsp1_valid = (state_q == ST_FULL) && own_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;
   import alu_pkg::*;

   localparam int W   = 32;
   localparam int OPW = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           req0_valid, req0_ready, req1_valid, req1_ready;
   logic [OPW-1:0] req0_op, req1_op;
   logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0]   rsp_y;
   logic           rsp_zero, rsp_err;

   int checks   = 0;
   int failures = 0;

   alu_share_ctrl #(.W(W), .OPW(OPW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_y      (rsp_y),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle later, 1 time unit past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int n0, n1, exp_port;
      logic [W-1:0] exp_y;

      rst_n = 1'b0;
      req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
      rsp0_ready = 0; rsp1_ready = 0;
      #2;
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_rsp_y", rsp_y, 0);
      check("rst_rsp_zero", rsp_zero, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      do_reset();

      // Port 0 ADD 5 + 7
      req0_valid = 1; req0_op = 5'(ALU_ADD); req0_a = 5; req0_b = 7; rsp0_ready = 1;
      #1;
      check("add_req0_ready", req0_ready, 1);
      check("add_req1_ready", req1_ready, 0);
      tick();
      req0_valid = 0;
      check("add_rsp0_valid", rsp0_valid, 1);
      check("add_rsp1_valid", rsp1_valid, 0);
      check("add_rsp_y", rsp_y, 12);
      check("add_rsp_zero", rsp_zero, 0);
      check("add_rsp_err", rsp_err, 0);
      tick();
      check("add_drain", rsp0_valid, 0);

      // Fresh reset so round-robin starts from port 0 again.
      do_reset();

      // Both ports always valid: grants 0,1,0,1,... one result per cycle.
      n0 = 0; n1 = 0; rsp0_ready = 1; rsp1_ready = 1;
      for (int k = 0; k < 6; k++) begin
         req0_valid = 1; req0_op = 5'(ALU_ADD); req0_a = W'(n0 + 3);  req0_b = 1;
         req1_valid = 1; req1_op = 5'(ALU_XOR); req1_a = W'(n1 + 16); req1_b = 32'hFF;
         exp_port = k % 2;
         exp_y = (exp_port == 0) ? W'(n0 + 4) : (W'(n1 + 16) ^ 32'hFF);
         #1;
         check("rr_req0_ready", req0_ready, (exp_port == 0));
         check("rr_req1_ready", req1_ready, (exp_port == 1));
         tick();
         check("rr_rsp0_valid", rsp0_valid, (exp_port == 0));
         check("rr_rsp1_valid", rsp1_valid, (exp_port == 1));
         check("rr_rsp_y", rsp_y, exp_y);
         if (exp_port == 0) n0++; else n1++;
      end
      req0_valid = 0; req1_valid = 0;
      tick();
      check("rr_drain0", rsp0_valid, 0);
      check("rr_drain1", rsp1_valid, 0);

      // Port 1 BEQ, response blocked for 3 cycles while port 0 waits.
      req1_valid = 1; req1_op = 5'(ALU_BEQ); req1_a = 32'h1234; req1_b = 32'h1234;
      rsp1_ready = 0; rsp0_ready = 1;
      #1;
      check("beq_req1_ready", req1_ready, 1);
      tick();
      req1_valid = 0;
      req0_valid = 1; req0_op = 5'(ALU_ADD); req0_a = 2; req0_b = 3;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("blk_rsp1_valid", rsp1_valid, 1);
         check("blk_rsp_y", rsp_y, 1);
         check("blk_req0_ready", req0_ready, 0);
         check("blk_req1_ready", req1_ready, 0);
         tick();
      end
      rsp1_ready = 1;
      #1;
      check("reuse_req0_ready", req0_ready, 1);
      tick();
      req0_valid = 0;
      check("reuse_rsp0_valid", rsp0_valid, 1);
      check("reuse_rsp1_valid", rsp1_valid, 0);
      check("reuse_rsp_y", rsp_y, 5);
      tick();
      check("reuse_drain", rsp0_valid, 0);

      // Invalid opcode, then SRA and SLTU back to back on port 0.
      req0_valid = 1; req0_op = 5'd20; req0_a = 3; req0_b = 4;
      tick();
      check("bad_rsp0_valid", rsp0_valid, 1);
      check("bad_rsp_y", rsp_y, 0);
      check("bad_rsp_zero", rsp_zero, 1);
      check("bad_rsp_err", rsp_err, 1);
      req0_op = 5'(ALU_SRA); req0_a = 32'h8000_0000; req0_b = 4;
      tick();
      check("sra_rsp_y", rsp_y, 32'hF800_0000);
      check("sra_rsp_err", rsp_err, 0);
      check("sra_rsp_zero", rsp_zero, 0);
      req0_op = 5'(ALU_SLTU); req0_a = 1; req0_b = 32'hFFFF_FFFF;
      tick();
      check("sltu_rsp_y", rsp_y, 1);
      check("sltu_rsp0_valid", rsp0_valid, 1);
      req0_valid = 0;
      tick();
      check("sltu_drain", rsp0_valid, 0);

      // Port 1 owns a result when reset hits mid-cycle.
      req1_valid = 1; req1_op = 5'(ALU_SUB); req1_a = 10; req1_b = 3; rsp1_ready = 0;
      tick();
      req1_valid = 0;
      check("pre_rst_rsp1_valid", rsp1_valid, 1);
      check("pre_rst_rsp_y", rsp_y, 7);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp1_valid", rsp1_valid, 0);
      check("mid_rst_rsp_y", rsp_y, 0);
      check("mid_rst_rsp_zero", rsp_zero, 0);
      check("mid_rst_req0_ready", req0_ready, 0);
      check("mid_rst_req1_ready", req1_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_rsp1_valid", rsp1_valid, 0);
      check("post_rst_rsp0_valid", rsp0_valid, 0);
      tick();
      check("post_rst_rsp1_valid2", rsp1_valid, 0);
      check("post_rst_req0_ready", req0_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
